// File: rtl/bubble_sort_engine.sv
// In-place bubble sort over the first len entries of a register array.
// Early exit on a swap-free pass; the array is loadable and readable when idle.
module bubble_sort_engine #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          start,
   input  logic [AW:0]   len,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] t_ram_addr,
   output logic [DW-1:0] t_ram_data,
   output logic          busy,
   output logic          sort_over,
   output logic [15:0]   swap_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      SWAP = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] mem_d [DEPTH];
   logic [AW-1:0] j_q, j_d;
   logic [AW:0]   limit_q, limit_d;
   logic          flag_q, flag_d;
   logic          busy_q, busy_d;
   logic          sort_over_q, sort_over_d;
   logic [15:0]   swap_cnt_q, swap_cnt_d;

   logic [AW:0]   len_c;
   logic [AW-1:0] j_nxt;
   logic [DW-1:0] word_lo, word_hi;
   logic          at_end;
   logic          advance;
   logic          adv_flag;

   assign len_c   = (len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : len;
   assign j_nxt   = j_q + 1'b1;
   assign word_lo = mem_q[j_q];
   assign word_hi = mem_q[j_nxt];
   assign at_end  = ({1'b0, j_q} == (limit_q - 1'b1));

   assign t_ram_data = mem_q[t_ram_addr];
   assign busy       = busy_q;
   assign sort_over  = sort_over_q;
   assign swap_cnt   = swap_cnt_q;

   always_comb begin
      state_d    = state_q;
      mem_d      = mem_q;
      j_d        = j_q;
      limit_d    = limit_q;
      flag_d     = flag_q;
      swap_cnt_d = swap_cnt_q;
      advance    = 1'b0;
      adv_flag   = flag_q;

      case (state_q)
         IDLE, DONE: begin
            // The write lands at the same edge as the start, so the sort sees it.
            if (wr_en) begin
               mem_d[wr_addr] = wr_data;
            end
            if (start) begin
               limit_d    = (len_c == '0) ? '0 : len_c - 1'b1;
               j_d        = '0;
               flag_d     = 1'b0;
               swap_cnt_d = '0;
               state_d    = CMP;
            end
         end
         CMP: begin
            // limit 0 means len was 0 or 1: nothing to compare.
            if (limit_q == '0) begin
               state_d = DONE;
            end else if (word_lo > word_hi) begin
               state_d = SWAP;
            end else begin
               advance  = 1'b1;
               adv_flag = flag_q;
            end
         end
         SWAP: begin
            mem_d[j_q]   = word_hi;
            mem_d[j_nxt] = word_lo;
            if (swap_cnt_q != 16'hFFFF) begin
               swap_cnt_d = swap_cnt_q + 16'd1;
            end
            flag_d   = 1'b1;
            advance  = 1'b1;
            adv_flag = 1'b1;
         end
         default: state_d = IDLE;
      endcase

      if (advance) begin
         if (!at_end) begin
            j_d     = j_nxt;
            state_d = CMP;
         end else if (!adv_flag || limit_q == 1) begin
            state_d = DONE;
         end else begin
            limit_d = limit_q - 1'b1;
            j_d     = '0;
            flag_d  = 1'b0;
            state_d = CMP;
         end
      end

      busy_d      = (state_d == CMP) || (state_d == SWAP);
      sort_over_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q     <= IDLE;
         j_q         <= '0;
         limit_q     <= '0;
         flag_q      <= 1'b0;
         busy_q      <= 1'b0;
         sort_over_q <= 1'b0;
         swap_cnt_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         j_q         <= j_d;
         limit_q     <= limit_d;
         flag_q      <= flag_d;
         busy_q      <= busy_d;
         sort_over_q <= sort_over_d;
         swap_cnt_q  <= swap_cnt_d;
         mem_q       <= mem_d;
      end
   end

endmodule

// File: tb/tb_bubble_sort_engine.sv
// Bench for bubble_sort_engine: fixed vectors, corner sequences, and random
// arrays checked against a plain bubble-sort reference model.
module tb_bubble_sort_engine;

   logic        clk = 1'b0;
   logic        resetn;
   logic        start;
   logic [5:0]  len;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [4:0]  t_ram_addr;
   logic [31:0] t_ram_data;
   logic        busy;
   logic        sort_over;
   logic [15:0] swap_cnt;

   always #5 clk = ~clk;

   bubble_sort_engine #(.DEPTH(32), .AW(5), .DW(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .start      (start),
      .len        (len),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .t_ram_addr (t_ram_addr),
      .t_ram_data (t_ram_data),
      .busy       (busy),
      .sort_over  (sort_over),
      .swap_cnt   (swap_cnt)
   );

   typedef struct packed {
      logic [5:0]        l;
      logic [3:0][31:0]  din;
      logic [3:0][31:0]  dout;
      logic [15:0]       swaps;
      logic [15:0]       cycles;
   } vec_t;

   vec_t        vecs [6];
   int          tests_run    = 0;
   int          tests_failed = 0;
   logic [31:0] exp_q [$];
   logic [31:0] model_mem [32];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic write_word(input int a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = a[4:0];
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic read_word(input int a, output logic [31:0] d);
      t_ram_addr = a[4:0];
      #1;
      d = t_ram_data;
   endtask

   // Counts busy cycles; optionally pokes a write and a start mid-sort.
   task automatic wait_done(input bit disturb, output int cycles);
      cycles = 0;
      while (busy && cycles < 5000) begin
         cycles++;
         if (disturb && cycles == 2) begin
            wr_en   = 1'b1;
            wr_addr = 5'd0;
            wr_data = 32'hFFFF_FFFF;
            start   = 1'b1;
         end else begin
            wr_en = 1'b0;
            start = 1'b0;
         end
         @(negedge clk);
      end
      wr_en = 1'b0;
      start = 1'b0;
      check("timeout", 64'(cycles >= 5000), 64'd0);
   endtask

   task automatic run_sort(input int l, input bit disturb, output int cycles);
      start = 1'b1;
      len   = l[5:0];
      @(negedge clk);
      start = 1'b0;
      wait_done(disturb, cycles);
   endtask

   task automatic check_mem(input string name, input int n);
      logic [31:0] d;
      for (int i = 0; i < n; i++) begin
         read_word(i, d);
         check(name, 64'(d), 64'(exp_q.pop_front()));
      end
   endtask

   task automatic model_sort(input int l, output int swaps, output int cycles);
      int          n;
      bit          sw;
      logic [31:0] t;
      n      = (l > 32) ? 32 : l;
      swaps  = 0;
      cycles = 0;
      if (n < 2) begin
         cycles = 1;
         return;
      end
      for (int lim = n - 1; lim >= 1; lim--) begin
         sw = 1'b0;
         for (int k = 0; k < lim; k++) begin
            cycles++;
            if (model_mem[k] > model_mem[k+1]) begin
               t              = model_mem[k];
               model_mem[k]   = model_mem[k+1];
               model_mem[k+1] = t;
               swaps++;
               cycles++;
               sw = 1'b1;
            end
         end
         if (!sw) break;
      end
   endtask

   initial begin
      int          cyc;
      int          m_swaps;
      int          m_cycles;
      int          l;
      logic [31:0] d;

      vecs[0] = '{l: 6'd4, din: {32'd1, 32'd2, 32'd3, 32'd4}, dout: {32'd4, 32'd3, 32'd2, 32'd1}, swaps: 16'd6, cycles: 16'd12};
      vecs[1] = '{l: 6'd4, din: {32'd4, 32'd3, 32'd2, 32'd1}, dout: {32'd4, 32'd3, 32'd2, 32'd1}, swaps: 16'd0, cycles: 16'd3};
      vecs[2] = '{l: 6'd2, din: {32'd5, 32'd7, 32'h1, 32'h8000_0000}, dout: {32'd5, 32'd7, 32'h8000_0000, 32'h1}, swaps: 16'd1, cycles: 16'd2};
      vecs[3] = '{l: 6'd1, din: {32'd1, 32'd2, 32'd3, 32'd9}, dout: {32'd1, 32'd2, 32'd3, 32'd9}, swaps: 16'd0, cycles: 16'd1};
      vecs[4] = '{l: 6'd0, din: {32'd0, 32'd1, 32'd2, 32'd8}, dout: {32'd0, 32'd1, 32'd2, 32'd8}, swaps: 16'd0, cycles: 16'd1};
      vecs[5] = '{l: 6'd4, din: {32'd3, 32'd1, 32'd2, 32'd2}, dout: {32'd3, 32'd2, 32'd2, 32'd1}, swaps: 16'd2, cycles: 16'd8};

      resetn     = 1'b0;
      start      = 1'b0;
      len        = '0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      t_ram_addr = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 64'(busy), 64'd0);
      check("reset_sort_over", 64'(sort_over), 64'd0);
      check("reset_swap_cnt", 64'(swap_cnt), 64'd0);
      read_word(5, d);
      check("reset_mem", 64'(d), 64'd0);
      resetn = 1'b1;
      @(negedge clk);

      for (int v = 0; v < 6; v++) begin
         for (int k = 0; k < 4; k++) write_word(k, vecs[v].din[k]);
         run_sort(int'(vecs[v].l), 1'b0, cyc);
         check($sformatf("vec%0d_cycles", v), 64'(cyc), 64'(vecs[v].cycles));
         check($sformatf("vec%0d_swaps", v), 64'(swap_cnt), 64'(vecs[v].swaps));
         check($sformatf("vec%0d_sort_over", v), 64'(sort_over), 64'd1);
         for (int k = 0; k < 4; k++) exp_q.push_back(vecs[v].dout[k]);
         check_mem($sformatf("vec%0d_mem", v), 4);
      end

      // Write and start ignored while busy.
      write_word(0, 32'd4); write_word(1, 32'd3); write_word(2, 32'd2); write_word(3, 32'd1);
      run_sort(4, 1'b1, cyc);
      check("disturb_cycles", 64'(cyc), 64'd12);
      check("disturb_swaps", 64'(swap_cnt), 64'd6);
      for (int k = 1; k <= 4; k++) exp_q.push_back(32'(k));
      check_mem("disturb_mem", 4);

      // Start together with a write: the sort sees the written word.
      write_word(0, 32'd5); write_word(1, 32'd6);
      start   = 1'b1;
      len     = 6'd2;
      wr_en   = 1'b1;
      wr_addr = 5'd1;
      wr_data = 32'd1;
      @(negedge clk);
      start = 1'b0;
      wr_en = 1'b0;
      wait_done(1'b0, cyc);
      check("startwr_cycles", 64'(cyc), 64'd2);
      check("startwr_swaps", 64'(swap_cnt), 64'd1);
      exp_q.push_back(32'd1);
      exp_q.push_back(32'd5);
      check_mem("startwr_mem", 2);

      for (int it = 0; it < 8; it++) begin
         for (int i = 0; i < 32; i++) begin
            d = (it % 2 == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            model_mem[i] = d;
            write_word(i, d);
         end
         l = (it == 0) ? 40 : (it == 1) ? 32 : int'($urandom_range(0, 32));
         model_sort(l, m_swaps, m_cycles);
         run_sort(l, 1'b0, cyc);
         check($sformatf("rand%0d_cycles", it), 64'(cyc), 64'(m_cycles));
         check($sformatf("rand%0d_swaps", it), 64'(swap_cnt), 64'(m_swaps));
         check($sformatf("rand%0d_sort_over", it), 64'(sort_over), 64'd1);
         for (int i = 0; i < 32; i++) exp_q.push_back(model_mem[i]);
         check_mem($sformatf("rand%0d_mem", it), 32);
      end

      // Reset in the middle of a sort.
      write_word(0, 32'd4); write_word(1, 32'd3); write_word(2, 32'd2); write_word(3, 32'd1);
      start = 1'b1;
      len   = 6'd4;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("midsort_busy_before", 64'(busy), 64'd1);
      resetn = 1'b0;
      @(negedge clk);
      check("midrst_busy", 64'(busy), 64'd0);
      check("midrst_sort_over", 64'(sort_over), 64'd0);
      check("midrst_swap_cnt", 64'(swap_cnt), 64'd0);
      for (int i = 0; i < 32; i++) exp_q.push_back(32'd0);
      check_mem("midrst_mem", 32);
      resetn = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
